// File: rtl/seq_detector_param.sv
// Programmable sequence detector: masked pattern compare over a symbol history,
// overlapping or non-overlapping detection, saturating match counter.
module seq_detector_param #(
    parameter int DATA_W  = 3,
    parameter int SEQ_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         valid,
    input  logic [DATA_W-1:0]            data,
    input  logic [SEQ_LEN*DATA_W-1:0]    pattern,
    input  logic [SEQ_LEN*DATA_W-1:0]    mask,
    input  logic                         overlap_en,
    output logic                         found,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(SEQ_LEN+1)-1:0] fill
);

    localparam int FILL_W = $clog2(SEQ_LEN + 1);
    localparam int HIST_W = SEQ_LEN * DATA_W;
    localparam logic [FILL_W-1:0] FULL = FILL_W'(SEQ_LEN);

    logic [HIST_W-1:0] hist;
    logic [HIST_W-1:0] hist_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;

    // Oldest symbol lives in the low bits; new data enters at the top element.
    always_comb begin
        hist_shift = {data, hist[HIST_W-1:DATA_W]};
        fill_inc   = (fill == FULL) ? FULL : fill + 1'b1;
        hit        = valid && (fill_inc == FULL) &&
                     (((hist_shift ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist        <= '0;
            fill        <= '0;
            found       <= 1'b0;
            match_count <= '0;
        end else if (clear) begin
            hist        <= '0;
            fill        <= '0;
            found       <= 1'b0;
            match_count <= '0;
        end else begin
            found <= hit;
            if (valid) begin
                hist <= hist_shift;
                fill <= (hit && !overlap_en) ? '0 : fill_inc;
            end
            if (hit && (match_count != '1)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed test-plan steps plus random traffic,
// checked against a queue-style reference model of the detection rules.
module tb_seq_detector_param;

    localparam int DW = 3;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic          valid;
    logic [DW-1:0] data;
    logic [SL*DW-1:0] pattern;
    logic [SL*DW-1:0] mask;
    logic          overlap_en;

    logic          found, found2;
    logic [7:0]    match_count;
    logic [1:0]    match_count2;
    logic [3:0]    fill, fill2;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  m_hist[SL];
    int  m_fill;
    bit  m_found;
    int  m_cnt, m_cnt2;

    int  def_seq[SL] = '{1, 5, 6, 0, 6, 6, 3, 5};

    always #5 clk = ~clk;

    seq_detector_param #(.DATA_W(DW), .SEQ_LEN(SL), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .valid(valid),
        .data(data), .pattern(pattern), .mask(mask),
        .overlap_en(overlap_en), .found(found),
        .match_count(match_count), .fill(fill)
    );

    seq_detector_param #(.DATA_W(DW), .SEQ_LEN(SL), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .valid(valid),
        .data(data), .pattern(pattern), .mask(mask),
        .overlap_en(overlap_en), .found(found2),
        .match_count(match_count2), .fill(fill2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SL; k++) m_hist[k] = 0;
        m_fill  = 0;
        m_found = 0;
        m_cnt   = 0;
        m_cnt2  = 0;
    endtask

    task automatic model_step(input bit v, input int d, input bit clr);
        bit hit;
        if (clr) begin
            model_reset();
        end else if (v) begin
            for (int k = 0; k < SL - 1; k++) m_hist[k] = m_hist[k+1];
            m_hist[SL-1] = d;
            if (m_fill < SL) m_fill++;
            hit = (m_fill == SL);
            for (int k = 0; k < SL; k++) begin
                if (((m_hist[k] ^ int'(pattern[k*DW +: DW])) &
                     int'(mask[k*DW +: DW])) != 0) hit = 0;
            end
            m_found = hit;
            if (hit) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!overlap_en) m_fill = 0;
            end
        end else begin
            m_found = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_found"}, 32'(found), 32'(m_found));
        chk({tag, "_count"}, 32'(match_count), 32'(m_cnt));
        chk({tag, "_fill"}, 32'(fill), 32'(m_fill));
        chk({tag, "_found2"}, 32'(found2), 32'(m_found));
        chk({tag, "_count2"}, 32'(match_count2), 32'(m_cnt2));
    endtask

    task automatic tick(input string tag, input bit v, input int d,
                        input bit clr);
        valid = v;
        data  = DW'(d);
        clear = clr;
        model_step(v, d, clr);
        @(posedge clk);
        #1;
        check_all(tag);
        valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic set_pattern(input int s[SL]);
        for (int k = 0; k < SL; k++) pattern[k*DW +: DW] = DW'(s[k]);
    endtask

    task automatic send_seq(input string tag, input int s[SL]);
        for (int k = 0; k < SL; k++) tick(tag, 1'b1, s[k], 1'b0);
    endtask

    initial begin
        int s[SL];
        bit rv;
        reset_n    = 1'b0;
        clear      = 1'b0;
        valid      = 1'b0;
        data       = '0;
        mask       = '1;
        overlap_en = 1'b1;
        set_pattern(def_seq);
        model_reset();
        #12;
        chk("reset_found", 32'(found), 32'd0);
        chk("reset_count", 32'(match_count), 32'd0);
        chk("reset_fill", 32'(fill), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic 8-symbol match
        send_seq("t1", def_seq);
        chk("t1_pulse", 32'(found), 32'd1);
        chk("t1_cnt", 32'(match_count), 32'd1);
        chk("t1_fill", 32'(fill), 32'd8);
        tick("t1_after", 1'b0, 0, 1'b0);
        chk("t1_single", 32'(found), 32'd0);

        // Gaps do not break a sequence
        tick("t2_clr", 1'b0, 0, 1'b1);
        for (int k = 0; k < 4; k++) tick("t2a", 1'b1, def_seq[k], 1'b0);
        for (int k = 0; k < 3; k++) tick("t2gap", 1'b0, 7, 1'b0);
        for (int k = 4; k < SL; k++) tick("t2b", 1'b1, def_seq[k], 1'b0);
        chk("t2_pulse", 32'(found), 32'd1);

        // Wrong last symbol
        tick("t2_clr2", 1'b0, 0, 1'b1);
        s = def_seq;
        s[7] = 4;
        send_seq("t2c", s);
        chk("t2_nopulse", 32'(found), 32'd0);
        chk("t2_cnt0", 32'(match_count), 32'd0);

        // Constant stream, overlapping then non-overlapping
        pattern = '1;
        for (int k = 0; k < 10; k++) tick("t3ov", 1'b1, 7, 1'b0);
        chk("t3_ov_cnt", 32'(match_count), 32'd3);
        tick("t3_clr", 1'b0, 0, 1'b1);
        overlap_en = 1'b0;
        for (int k = 0; k < 10; k++) tick("t3no", 1'b1, 7, 1'b0);
        chk("t3_no_cnt", 32'(match_count), 32'd1);
        chk("t3_no_fill", 32'(fill), 32'd2);
        overlap_en = 1'b1;

        // Don't-care element 3
        tick("t4_clr", 1'b0, 0, 1'b1);
        set_pattern(def_seq);
        mask[3*DW +: DW] = '0;
        s = def_seq;
        s[3] = 7;
        send_seq("t4a", s);
        chk("t4_match", 32'(found), 32'd1);
        s[1] = 7;
        tick("t4_clr2", 1'b0, 0, 1'b1);
        send_seq("t4b", s);
        chk("t4_nomatch", 32'(found), 32'd0);
        mask = '1;

        // Saturation of the narrow counter, then clear with valid
        pattern = '1;
        tick("t5_clr", 1'b0, 0, 1'b1);
        for (int k = 0; k < 12; k++) tick("t5", 1'b1, 7, 1'b0);
        chk("t5_cnt", 32'(match_count), 32'd5);
        chk("t5_cnt2_sat", 32'(match_count2), 32'd3);
        tick("t5_clrv", 1'b1, 7, 1'b1);
        chk("t5_clr_cnt", 32'(match_count), 32'd0);
        chk("t5_clr_fill", 32'(fill), 32'd0);

        // Asynchronous reset mid-sequence
        set_pattern(def_seq);
        for (int k = 0; k < 5; k++) tick("t6a", 1'b1, def_seq[k], 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_found", 32'(found), 32'd0);
        chk("t6_rst_fill", 32'(fill), 32'd0);
        chk("t6_rst_cnt2", 32'(match_count2), 32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 5; k < SL; k++) tick("t6b", 1'b1, def_seq[k], 1'b0);
        chk("t6_nomatch", 32'(match_count), 32'd0);
        send_seq("t6c", def_seq);
        chk("t6_match", 32'(found), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                mask = SL*DW'($urandom & $urandom & $urandom);
                overlap_en = 1'($urandom);
                for (int k = 0; k < SL; k++) s[k] = $urandom_range(0, 7);
                set_pattern(s);
            end
            rv = ($urandom_range(0, 3) != 0);
            tick("rnd", rv, $urandom_range(0, 7), ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised, programmable successor to the fixed 8-step 3-bit sequence detector. It watches a stream of qualified DATA_W-bit symbols and flags each occurrence of a runtime-programmable SEQ_LEN-symbol pattern. Per-symbol don't-care masking, selectable overlapping or non-overlapping detection, and a saturating match counter are provided. It sits on the symbol stream after the input sampler and feeds the event/status logic.

Parameters:
DATA_W, 3, width of one symbol
SEQ_LEN, 8, number of symbols in the pattern (>= 2)
CNT_W, 8, width of the match counter

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush of history, fill level, counter and found
valid  input  1  data is a new symbol this cycle
data  input  DATA_W  input symbol
pattern  input  SEQ_LEN*DATA_W  expected symbols; element k = bits [k*DATA_W +: DATA_W]; element 0 is the oldest (first) symbol
mask  input  SEQ_LEN*DATA_W  per-bit compare enable, same layout; 0 = don't care
overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping
found  output  1  one-cycle pulse per detected match
match_count  output  CNT_W  number of matches since reset/clear, saturating
fill  output  clog2(SEQ_LEN+1)  symbols currently held toward a match (0..SEQ_LEN)

Behaviour:
- Reset value (reset_n low, asynchronous): history all zero, fill=0, found=0, match_count=0.
- History: SEQ_LEN-entry shift register of the most recent valid symbols. On a valid cycle, each entry shifts one place older and data enters as the newest entry, which is compared against element SEQ_LEN-1. Cycles with valid=0 hold all state and leave found at 0. Gaps between symbols are allowed and do not break a sequence.
- fill: increments on each valid symbol and saturates at SEQ_LEN.
- Match condition: evaluated on the valid cycle using the shifted-in data. All SEQ_LEN elements must satisfy ((hist_k XOR pattern_k) AND mask_k) == 0, and the post-shift fill must equal SEQ_LEN. A fully zero mask therefore matches every symbol once fill reaches SEQ_LEN.
- found: registered. It is high for exactly the one cycle after the valid cycle that completes a match, and low in every other cycle.
- Overlap:
  - overlap_en=1: history and fill are kept after a match, so consecutive symbols can complete further matches (for example, every cycle on a constant stream).
  - overlap_en=0: fill is forced to 0 on the matching cycle, so the next match needs SEQ_LEN fresh symbols. overlap_en is sampled on the matching cycle.
- match_count: increments by 1 on each match and saturates at 2^CNT_W-1, with no wrap.
- clear: sets history and fill to 0, found to 0 and match_count to 0 on the next edge. clear has priority over a coincident valid, and that symbol is discarded.
- pattern/mask: compared live each valid cycle with no internal copy. A change takes effect on the next valid symbol. The history is not cleared when pattern or mask changes; software asserts clear when it needs a clean restart.
- Reset mid-sequence: all partial progress is lost. After release, a complete sequence is required before found can assert.
- Pipeline: one register stage. Combinational paths run only from inputs to next-state logic, never to outputs.

Test Plan:
- Defaults; pattern = 001,101,110,000,110,110,011,101; mask all ones; overlap_en=1; drive these 8 symbols on consecutive valid cycles -> found=1 for exactly one cycle, in the cycle after the 8th symbol; match_count=1; fill=8.
- Same pattern; insert 3 valid=0 cycles between symbols 4 and 5 -> still one found pulse after the 8th symbol. Then replace the 8th symbol with 100 -> no pulse, match_count unchanged.
- pattern all 111, mask all ones, 10 consecutive 111 symbols:
  - overlap_en=1 -> pulses after symbols 8, 9 and 10; match_count=3.
  - repeat after clear with overlap_en=0 -> single pulse after symbol 8; match_count=1; fill=2 at end.
- Default pattern with mask element 3 = 000; send 001,101,110,111,110,110,011,101 -> match; send the same with symbol 1 = 111 -> no match.
- CNT_W=2 override, constant-stream pattern, overlap_en=1, 12 symbols -> 5 matches, match_count saturates at 3. Then clear asserted together with valid -> match_count=0, fill=0, found=0 on the next cycle, and the coincident symbol is ignored.
- Deassert reset_n asynchronously after 5 correct symbols, then release -> outputs 0 immediately. The remaining 3 symbols give no match; a full 8-symbol sequence afterwards gives one pulse.
